bitstream_fetch_buffer: RTL and testbench

- Sits directly downstream of the bitstream word RAM and upstream of the syntax parser.
- Issues sequential 16-bit word reads to the RAM, which has an active-low read enable and returns data one cycle after the read.
- Packs the returned words into a 64-bit MSB-first shift buffer.
- Presents a 16-bit bit-aligned look-ahead window; the parser consumes 0..16 bits per cycle.

---
 rtl/bitstream_fetch_buffer_if.sv | 21 ++
 rtl/bitstream_fetch_buffer.sv | 131 +++++++++++++
 tb/tb_bitstream_fetch_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitstream_fetch_buffer_if.sv
// Word-read bus between the fetch buffer (master) and the bitstream word RAM (slave).
// The RAM answers one cycle after an active-low read enable.
interface bitstream_fetch_buffer_if #(
    parameter int ADDR_W = 17
) ();
    logic              BitStream_ram_ren;
    logic [ADDR_W-1:0] BitStream_ram_addr;
    logic [15:0]       BitStream_ram_data;

    modport master (
        output BitStream_ram_ren,
        output BitStream_ram_addr,
        input  BitStream_ram_data
    );

    modport slave (
        input  BitStream_ram_ren,
        input  BitStream_ram_addr,
        output BitStream_ram_data
    );
endinterface

// File: rtl/bitstream_fetch_buffer.sv
// Sequential RAM word fetcher feeding a 64-bit MSB-first shift buffer that
// exposes a 16-bit bit-aligned look-ahead window to the syntax parser.
module bitstream_fetch_buffer #(
    parameter int                ADDR_W    = 17,
    parameter logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         start_addr,
    bitstream_fetch_buffer_if.master  ram,
    input  logic [4:0]                bits_used,
    output logic [15:0]               window,
    output logic                      window_valid,
    output logic [20:0]               bit_pos,
    output logic                      byte_aligned,
    output logic                      eos
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_END   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       buf_q, buf_d;
    logic [6:0]        level_q, level_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [20:0]       bit_pos_q, bit_pos_d;
    logic              ren_q, ren_d;
    logic              valid_q, valid_d;
    logic              eos_q, eos_d;

    logic [4:0]        used_s;
    logic [6:0]        level_after_s;
    logic [63:0]       shifted_s;
    logic [63:0]       merged_s;
    logic              issue_s;

    // Consume/shift, merge of the returning word, fetch issue and next-state decode
    always_comb begin
        used_s        = 5'd0;
        buf_d         = buf_q;
        level_d       = level_q;
        pending_d     = 1'b0;
        fetch_addr_d  = fetch_addr_q;
        bit_pos_d     = bit_pos_q;
        state_d       = state_q;
        issue_s       = ~ren_q;

        if (valid_q) begin
            used_s = (bits_used > 5'd16) ? 5'd16 : bits_used;
        end else begin
            used_s = 5'd0;
        end
        shifted_s     = buf_q << used_s;
        level_after_s = level_q - 7'(used_s);
        // New word lands directly behind the bits that survive this cycle's shift
        merged_s      = shifted_s | ({ram.BitStream_ram_data, 48'd0} >> level_after_s);

        if (start) begin
            buf_d        = 64'd0;
            level_d      = 7'd0;
            bit_pos_d    = 21'd0;
            pending_d    = 1'b0;
            fetch_addr_d = start_addr;
            state_d      = ST_FETCH;
        end else begin
            bit_pos_d = bit_pos_q + 21'(used_s);
            if (pending_q) begin
                buf_d   = merged_s;
                level_d = level_after_s + 7'd16;
            end else begin
                buf_d   = shifted_s;
                level_d = level_after_s;
            end
            if (issue_s) begin
                pending_d = 1'b1;
                if (fetch_addr_q == LAST_ADDR) begin
                    state_d = ST_END;
                end else begin
                    fetch_addr_d = fetch_addr_q + ADDR_W'(1);
                end
            end else begin
                pending_d = 1'b0;
            end
        end

        // Outstanding words are counted so the buffer can never be overfilled
        ren_d   = ~((state_d == ST_FETCH) &&
                    (({1'b0, level_d} + {3'd0, pending_d, 4'd0}) <= 8'd32));
        valid_d = (level_d >= 7'd16);
        eos_d   = (state_d == ST_END) && !pending_d && (level_d < 7'd16);
    end

    // State, datapath and registered output update with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            buf_q        <= 64'd0;
            level_q      <= 7'd0;
            pending_q    <= 1'b0;
            fetch_addr_q <= {ADDR_W{1'b0}};
            bit_pos_q    <= 21'd0;
            ren_q        <= 1'b1;
            valid_q      <= 1'b0;
            eos_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            level_q      <= level_d;
            pending_q    <= pending_d;
            fetch_addr_q <= fetch_addr_d;
            bit_pos_q    <= bit_pos_d;
            ren_q        <= ren_d;
            valid_q      <= valid_d;
            eos_q        <= eos_d;
        end
    end

    assign ram.BitStream_ram_ren  = ren_q;
    assign ram.BitStream_ram_addr = fetch_addr_q;
    assign window                 = buf_q[63:48];
    assign window_valid           = valid_q;
    assign bit_pos                = bit_pos_q;
    assign byte_aligned           = (bit_pos_q[2:0] == 3'd0);
    assign eos                    = eos_q;

endmodule

// File: tb/tb_bitstream_fetch_buffer.sv
// Directed plus randomized bench for bitstream_fetch_buffer, checked against a
// bit-queue reference model of the stream.
module tb_bitstream_fetch_buffer;

    localparam logic [16:0] LAST = 17'h1FFFF;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [16:0] start_addr;
    logic [4:0]  bits_used;
    logic [15:0] window;
    logic        window_valid;
    logic [20:0] bit_pos;
    logic        byte_aligned;
    logic        eos;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:131071];

    bitstream_fetch_buffer_if #(.ADDR_W(17)) ram_if ();

    bitstream_fetch_buffer #(.ADDR_W(17), .LAST_ADDR(LAST)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .start_addr   (start_addr),
        .ram          (ram_if),
        .bits_used    (bits_used),
        .window       (window),
        .window_valid (window_valid),
        .bit_pos      (bit_pos),
        .byte_aligned (byte_aligned),
        .eos          (eos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM: data one cycle after ren=0, junk otherwise
    always @(posedge clk) begin
        if (!ram_if.BitStream_ram_ren)
            ram_if.BitStream_ram_data <= mem[ram_if.BitStream_ram_addr];
        else
            ram_if.BitStream_ram_data <= 16'($urandom);
    end

    // Reference model: the buffer as a queue of bits, oldest first
    bit          mq[$];
    bit          m_pend;
    bit          m_issue;
    logic [16:0] m_paddr;
    logic [16:0] m_faddr;
    int          m_mode;      // 0 idle, 1 fetching, 2 ended
    int unsigned m_bitpos;

    task automatic model_edge(input logic st, input logic [16:0] sa,
                              input logic [4:0] bu, input logic rn);
        int used;
        logic [15:0] w;
        if (!rn) begin
            mq.delete();
            m_pend = 1'b0; m_faddr = 17'd0; m_mode = 0; m_bitpos = 0;
        end else if (st) begin
            mq.delete();
            m_pend = 1'b0; m_faddr = sa; m_mode = 1; m_bitpos = 0;
        end else begin
            used = (mq.size() >= 16) ? ((int'(bu) > 16) ? 16 : int'(bu)) : 0;
            for (int i = 0; i < used; i++) void'(mq.pop_front());
            m_bitpos = (m_bitpos + used) % (1 << 21);
            if (m_pend) begin
                w = mem[m_paddr];
                for (int i = 15; i >= 0; i--) mq.push_back(w[i]);
            end
            if (m_issue) begin
                m_pend  = 1'b1;
                m_paddr = m_faddr;
                if (m_faddr == LAST) m_mode = 2;
                else m_faddr = m_faddr + 17'd1;
            end else begin
                m_pend = 1'b0;
            end
        end
        m_issue = (m_mode == 1) && ((mq.size() + 16 * int'(m_pend)) <= 32);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] ew;
        ew = 16'd0;
        for (int i = 0; i < 16; i++)
            if (i < mq.size()) ew[15-i] = mq[i];
        chk("ren", 32'(ram_if.BitStream_ram_ren), 32'(!m_issue));
        if (m_issue || m_mode == 0)
            chk("addr", 32'(ram_if.BitStream_ram_addr), 32'(m_faddr));
        chk("window", 32'(window), 32'(ew));
        chk("window_valid", 32'(window_valid), 32'(mq.size() >= 16));
        chk("bit_pos", 32'(bit_pos), 32'(m_bitpos));
        chk("byte_aligned", 32'(byte_aligned), 32'((m_bitpos % 8) == 0));
        chk("eos", 32'(eos), 32'((m_mode == 2) && !m_pend && (mq.size() < 16)));
    endtask

    task automatic step(input logic st, input logic [16:0] sa,
                        input logic [4:0] bu, input logic rn);
        start = st; start_addr = sa; bits_used = bu; reset_n = rn;
        @(posedge clk);
        model_edge(st, sa, bu, rn);
        #1;
        check_all();
    endtask

    initial begin
        int reads;
        int words;
        int waited;
        logic [16:0] ra;

        for (int i = 0; i < 131072; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
        mem[17'h100] = 16'hC0DE;
        mq.delete();
        m_pend = 1'b0; m_issue = 1'b0; m_paddr = 17'd0; m_faddr = 17'd0;
        m_mode = 0; m_bitpos = 0;
        start = 1'b0; start_addr = 17'd0; bits_used = 5'd0; reset_n = 1'b0;

        // Reset then idle
        step(1'b0, 17'd0, 5'd0, 1'b0);
        step(1'b0, 17'd0, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 17'd0, 5'd0, 1'b1);
        chk("idle_ren", 32'(ram_if.BitStream_ram_ren), 32'd1);
        chk("idle_byte_aligned", 32'(byte_aligned), 32'd1);

        // Start at 0: reads in cycles 1..3, first window in cycle 3
        step(1'b1, 17'd0, 5'd0, 1'b1);
        chk("c1_ren", 32'(ram_if.BitStream_ram_ren), 32'd0);
        chk("c1_addr", 32'(ram_if.BitStream_ram_addr), 32'd0);
        step(1'b0, 17'd0, 5'd0, 1'b1);
        chk("c2_addr", 32'(ram_if.BitStream_ram_addr), 32'd1);
        chk("c2_valid", 32'(window_valid), 32'd0);
        step(1'b0, 17'd0, 5'd0, 1'b1);
        chk("c3_addr", 32'(ram_if.BitStream_ram_addr), 32'd2);
        chk("c3_valid", 32'(window_valid), 32'd1);
        chk("c3_window", 32'(window), 32'h1234);
        step(1'b0, 17'd0, 5'd4, 1'b1);
        chk("c4_window", 32'(window), 32'h2345);
        chk("c4_bit_pos", 32'(bit_pos), 32'd4);
        chk("c4_byte_aligned", 32'(byte_aligned), 32'd0);
        step(1'b0, 17'd0, 5'd4, 1'b1);
        chk("c5_window", 32'(window), 32'h3456);
        chk("c5_byte_aligned", 32'(byte_aligned), 32'd1);

        // No consumption: fill stops, window holds, then oversized consume saturates
        step(1'b1, 17'd0, 5'd0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 17'd0, 5'd0, 1'b1);
        chk("hold_ren", 32'(ram_if.BitStream_ram_ren), 32'd1);
        chk("hold_window", 32'(window), 32'h1234);
        step(1'b0, 17'd0, 5'd20, 1'b1);
        chk("sat_bit_pos", 32'(bit_pos), 32'd16);
        chk("sat_window", 32'(window), 32'h5678);

        // Last four words of RAM at full rate: exactly four reads, then eos
        ra = LAST - 17'd3;
        reads = 0; words = 0;
        step(1'b1, ra, 5'd16, 1'b1);
        if (!ram_if.BitStream_ram_ren) reads++;
        for (int i = 0; i < 11; i++) begin
            if (window_valid) begin
                chk("end_word", 32'(window), 32'(mem[ra + 17'(words)]));
                words++;
            end
            step(1'b0, 17'd0, 5'd16, 1'b1);
            if (!ram_if.BitStream_ram_ren) reads++;
        end
        chk("end_reads", 32'(reads), 32'd4);
        chk("end_words", 32'(words), 32'd4);
        chk("end_eos", 32'(eos), 32'd1);
        chk("end_valid", 32'(window_valid), 32'd0);

        // Restart while a word is returning: that word is discarded
        step(1'b1, 17'd0, 5'd0, 1'b1);
        step(1'b0, 17'd0, 5'd0, 1'b1);
        step(1'b1, 17'h100, 5'd0, 1'b1);
        chk("restart_bit_pos", 32'(bit_pos), 32'd0);
        waited = 0;
        while (!window_valid && waited < 8) begin
            step(1'b0, 17'd0, 5'd0, 1'b1);
            waited++;
        end
        chk("restart_valid_timeout", 32'(window_valid), 32'd1);
        chk("restart_window", 32'(window), 32'hC0DE);

        // Reset mid-fill, then start together with reset
        step(1'b1, 17'd0, 5'd0, 1'b1);
        step(1'b0, 17'd0, 5'd0, 1'b1);
        step(1'b0, 17'd0, 5'd0, 1'b1);
        step(1'b0, 17'd0, 5'd0, 1'b0);
        chk("rst_ren", 32'(ram_if.BitStream_ram_ren), 32'd1);
        chk("rst_addr", 32'(ram_if.BitStream_ram_addr), 32'd0);
        chk("rst_window", 32'(window), 32'd0);
        chk("rst_valid", 32'(window_valid), 32'd0);
        chk("rst_eos", 32'(eos), 32'd0);
        step(1'b1, 17'd5, 5'd0, 1'b0);
        step(1'b0, 17'd0, 5'd0, 1'b1);
        chk("rst_wins_ren", 32'(ram_if.BitStream_ram_ren), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic st;
            logic rn;
            logic [16:0] sa;
            logic [4:0] bu;
            st = ($urandom_range(0, 99) < 4);
            rn = ($urandom_range(0, 199) != 0);
            sa = ($urandom_range(0, 1) == 1) ? (LAST - 17'($urandom_range(0, 12)))
                                             : 17'($urandom);
            bu = ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 31));
            if (i < 2) st = 1'b1;
            step(st, sa, bu, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
